// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for the seq_ctrl instruction sequencer: opcodes, FSM states,
// writeback source codes and the lane-index width helper.
package seq_ctrl_pkg;

  localparam logic [3:0] OP_VADD = 4'd0;
  localparam logic [3:0] OP_VDOT = 4'd1;
  localparam logic [3:0] OP_SMUL = 4'd2;
  localparam logic [3:0] OP_SST  = 4'd3;
  localparam logic [3:0] OP_VLD  = 4'd4;
  localparam logic [3:0] OP_VST  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SLH  = 4'd7;
  localparam logic [3:0] OP_J    = 4'd8;
  localparam logic [3:0] OP_NOP  = 4'd9;

  typedef enum logic [2:0] {
    ST_RST, ST_FETCH, ST_DECODE, ST_FPU, ST_ADDR, ST_LOAD, ST_STORE, ST_WB
  } state_e;

  localparam logic [1:0] WB_FPU_S = 2'd0;
  localparam logic [1:0] WB_SHIFT = 2'd1;
  localparam logic [1:0] WB_FPU_V = 2'd2;
  localparam logic [1:0] WB_LDBUF = 2'd3;

  // A single-lane vector still needs a one-bit lane index port.
  function automatic int lane_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_ctrl_if.sv
// Memory request/acknowledge port of the sequencer; master = sequencer, slave = memory.
interface seq_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic              mem_ack;
  logic [15:0]       mem_rdata;

  modport master (output mem_addr, mem_rd, mem_wr, input mem_ack, mem_rdata);
  modport slave  (input mem_addr, mem_rd, mem_wr, output mem_ack, mem_rdata);
endinterface

// File: rtl/seq_addr_gen.sv
// Effective-address register, vector lane counter and per-beat address for VLD/VST/SST.
module seq_addr_gen
  import seq_ctrl_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int OFF_W  = 6,
  parameter int VLANES = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [15:0]                 base_data,
  input  logic [OFF_W-1:0]            off,
  input  logic                        ea_load,
  input  logic                        beat_adv,
  output logic [lane_w(VLANES)-1:0]   lane_idx,
  output logic [ADDR_W-1:0]           beat_addr,
  output logic                        last_beat
);
  localparam int LW = lane_w(VLANES);

  logic [ADDR_W-1:0]        ea_q, ea_d;
  logic [LW-1:0]            lane_q, lane_d;
  logic signed [OFF_W-1:0]  off_s;
  logic signed [ADDR_W-1:0] off_x;

  assign off_s     = off;
  assign off_x     = ADDR_W'(off_s);
  assign last_beat = (lane_q == LW'(VLANES - 1));
  assign lane_idx  = lane_q;

  // beat_addr is the address for the cycle after this edge, so the top can register it.
  always_comb begin
    ea_d   = ea_q;
    lane_d = lane_q;
    if (ea_load) begin
      ea_d   = ADDR_W'(base_data) + off_x;
      lane_d = '0;
    end else if (beat_adv) begin
      lane_d = last_beat ? '0 : lane_q + LW'(1);
    end
    beat_addr = ea_d + ADDR_W'(lane_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ea_q   <= '0;
      lane_q <= '0;
    end else begin
      ea_q   <= ea_d;
      lane_q <= lane_d;
    end
  end

endmodule

// File: rtl/seq_ctrl.sv
// Multicycle vector/scalar instruction sequencer: fetch, decode, FPU handshake, vector
// load/store beats and writeback strobes. Optional FPU watchdog: SEQ_FPU_TIMEOUT_EN.
module seq_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int OFF_W       = 6,
  parameter int VLANES      = 16,
  parameter int FPU_TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  seq_ctrl_if.master                mem,
  output logic [15:0]               instr,
  input  logic [15:0]               base_data,
  output logic [ADDR_W-1:0]         pc,
  output logic                      fpu_start,
  input  logic                      fpu_done,
  output logic [lane_w(VLANES)-1:0] lane_idx,
  output logic                      lane_we,
  output logic                      sreg_we,
  output logic                      vreg_we,
  output logic [1:0]                wb_sel,
  output logic                      instr_done,
  output logic                      illegal
`ifdef SEQ_FPU_TIMEOUT_EN
  ,
  output logic                      fpu_timeout
`endif
);
  if (FPU_TIMEOUT < 1 || OFF_W < 1 || OFF_W > 8 || VLANES < 1) begin : g_param_chk
    $error("seq_ctrl: parameter out of range");
  end

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        pc_q, pc_d;
  logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
  logic [15:0]              instr_q, instr_d;
  logic [1:0]               wb_sel_q, wb_sel_d;
  logic                     fpu_first_q, fpu_first_d;
  logic                     ea_load, beat_adv, last_beat, mem_rd, mem_wr;
  logic [ADDR_W-1:0]        beat_addr;
  logic [3:0]               opcode;
  logic signed [11:0]       jofs;
  logic signed [ADDR_W-1:0] jofs_x;

  assign opcode   = instr_q[15:12];
  assign jofs     = instr_q[11:0];
  assign jofs_x   = ADDR_W'(jofs);
  assign mem_rd   = (state_q == ST_FETCH) || (state_q == ST_LOAD);
  assign mem_wr   = (state_q == ST_STORE);
  assign ea_load  = (state_q == ST_ADDR);
  assign beat_adv = ((state_q == ST_LOAD) || (state_q == ST_STORE)) && mem.mem_ack;

  assign mem.mem_addr = mem_addr_q;
  assign mem.mem_rd   = mem_rd;
  assign mem.mem_wr   = mem_wr;
  assign instr        = instr_q;
  assign pc           = pc_q;
  assign wb_sel       = wb_sel_q;

  seq_addr_gen #(
    .ADDR_W (ADDR_W),
    .OFF_W  (OFF_W),
    .VLANES (VLANES)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .base_data (base_data),
    .off       (instr_q[OFF_W-1:0]),
    .ea_load   (ea_load),
    .beat_adv  (beat_adv),
    .lane_idx  (lane_idx),
    .beat_addr (beat_addr),
    .last_beat (last_beat)
  );

`ifdef SEQ_FPU_TIMEOUT_EN
  localparam int CW = $clog2(FPU_TIMEOUT + 1);
  logic [CW-1:0] to_cnt_q, to_cnt_d;
  logic          to_hit;
  assign to_hit = (to_cnt_q == CW'(FPU_TIMEOUT - 1));
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    wb_sel_d    = wb_sel_q;
    fpu_first_d = 1'b0;
    fpu_start   = 1'b0;
    lane_we     = 1'b0;
    sreg_we     = 1'b0;
    vreg_we     = 1'b0;
    instr_done  = 1'b0;
    illegal     = 1'b0;
`ifdef SEQ_FPU_TIMEOUT_EN
    fpu_timeout = 1'b0;
`endif
    case (state_q)
      ST_RST: state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem.mem_ack) begin
          instr_d = mem.mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (opcode)
          OP_VADD, OP_SMUL: begin
            state_d = ST_FPU; fpu_first_d = 1'b1; wb_sel_d = WB_FPU_V;
          end
          OP_VDOT: begin
            state_d = ST_FPU; fpu_first_d = 1'b1; wb_sel_d = WB_FPU_S;
          end
          OP_SST, OP_VST: state_d = ST_ADDR;
          OP_VLD: begin
            state_d = ST_ADDR; wb_sel_d = WB_LDBUF;
          end
          OP_SLL, OP_SLH: begin
            state_d = ST_WB; wb_sel_d = WB_SHIFT;
          end
          OP_J: begin
            pc_d = pc_q + jofs_x; instr_done = 1'b1; state_d = ST_FETCH;
          end
          OP_NOP: begin
            instr_done = 1'b1; state_d = ST_FETCH;
          end
          default: begin
            illegal = 1'b1; instr_done = 1'b1; state_d = ST_FETCH;
          end
        endcase
      end
      ST_FPU: begin
        // A done seen in the start cycle belongs to an earlier operation.
        fpu_start = fpu_first_q;
        if (!fpu_first_q && fpu_done) begin
          state_d = ST_WB;
`ifdef SEQ_FPU_TIMEOUT_EN
        end else if (to_hit) begin
          fpu_timeout = 1'b1; instr_done = 1'b1; state_d = ST_FETCH;
`endif
        end
      end
      ST_ADDR: state_d = (opcode == OP_VLD) ? ST_LOAD : ST_STORE;
      ST_LOAD: begin
        if (mem.mem_ack) begin
          lane_we = 1'b1;
          if (last_beat) state_d = ST_WB;
        end
      end
      ST_STORE: begin
        if (mem.mem_ack && ((opcode == OP_SST) || last_beat)) begin
          instr_done = 1'b1; state_d = ST_FETCH;
        end
      end
      ST_WB: begin
        sreg_we    = (opcode == OP_VDOT) || (opcode == OP_SLL) || (opcode == OP_SLH);
        vreg_we    = (opcode == OP_VADD) || (opcode == OP_SMUL) || (opcode == OP_VLD);
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end
      default: state_d = ST_RST;
    endcase
  end

  always_comb begin
    mem_addr_d = pc_d;
    if ((state_d == ST_LOAD) || (state_d == ST_STORE)) mem_addr_d = beat_addr;
`ifdef SEQ_FPU_TIMEOUT_EN
    to_cnt_d = '0;
    if ((state_q == ST_FPU) && (state_d == ST_FPU)) to_cnt_d = to_cnt_q + CW'(1);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RST;
      pc_q        <= '0;
      instr_q     <= '0;
      mem_addr_q  <= '0;
      wb_sel_q    <= '0;
      fpu_first_q <= 1'b0;
`ifdef SEQ_FPU_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      mem_addr_q  <= mem_addr_d;
      wb_sel_q    <= wb_sel_d;
      fpu_first_q <= fpu_first_d;
`ifdef SEQ_FPU_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

endmodule

// File: doc/seq_ctrl.md
Name: seq_ctrl

Overview:
Parametrised multicycle instruction sequencer for the vector/scalar CPU. It owns the PC, fetches over a req/ack memory port, latches the instruction, and computes effective addresses. It runs multi-beat vector loads/stores of VLANES words, starts the FPU and waits for completion, and issues register-file writeback strobes.

Parameters:
ADDR_W, 16, memory/PC address width
OFF_W, 6, signed load/store offset field width (instr[OFF_W-1:0]), 1..8
VLANES, 16, 16-bit words per vector (beats per VLD/VST), >=1
FPU_TIMEOUT, 64, max cycles waited for fpu_done (optional feature only)

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
mem_addr  out  ADDR_W  memory address
mem_rd  out  1  read request, held until mem_ack
mem_wr  out  1  write request, held until mem_ack
mem_ack  in  1  memory completes current beat this cycle
mem_rdata  in  16  read data, valid when mem_ack
instr  out  16  latched current instruction
base_data  in  16  scalar register read (rs = instr[8:6]), address base
pc  out  ADDR_W  program counter
fpu_start  out  1  one-cycle FPU start pulse
fpu_done  in  1  FPU result ready
lane_idx  out  clog2(VLANES) (min 1)  current vector beat
lane_we  out  1  VLD beat strobe: write mem_rdata into lane lane_idx of load buffer
sreg_we  out  1  scalar register write strobe (rd = instr[11:9])
vreg_we  out  1  vector register write strobe (rd = instr[11:9])
wb_sel  out  2  0 FPU scalar, 1 sll/slh, 2 FPU vector, 3 load buffer
instr_done  out  1  one-cycle pulse when an instruction retires
illegal  out  1  one-cycle pulse for an undefined opcode

Behaviour:
- Opcodes in instr[15:12]: VADD=0, VDOT=1, SMUL=2, SST=3, VLD=4, VST=5, SLL=6, SLH=7, J=8, NOP=9. Codes 10-15 are illegal.
- Async reset: state=RST. pc, instr, lane_idx, mem_addr=0. All strobes and requests are 0 immediately, even mid-beat. Any in-flight beat is abandoned.
- States: RST -> FETCH (1 cycle).
- FETCH: mem_rd=1, mem_addr=pc. On mem_ack: instr<=mem_rdata, pc<=pc+1 (mod 2^ADDR_W), -> DECODE.
- DECODE (1 cycle) routes by opcode:
  - VADD/VDOT/SMUL -> FPU.
  - SST/VLD/VST -> ADDR.
  - SLL/SLH -> WB.
  - J: pc <= pc + sext(instr[11:0]), where pc is already incremented. Pulse instr_done, -> FETCH.
  - NOP: pulse instr_done, -> FETCH.
  - Illegal: pulse illegal and instr_done, -> FETCH.
- FPU: fpu_start pulses on the first cycle only. fpu_done is honoured from the cycle after the start pulse and ignored in the start cycle. On fpu_done -> WB.
- ADDR (1 cycle): ea = base_data[ADDR_W-1:0] + sext(instr[OFF_W-1:0]), wrapping. lane_idx <= 0. SST -> STORE, VLD -> LOAD, VST -> STORE.
- LOAD: mem_rd=1, mem_addr = ea + lane_idx (wraps).
  - Each mem_ack: lane_we=1 the same cycle, lane_idx++.
  - On the ack with lane_idx==VLANES-1 -> WB. mem_rd stays high between beats.
- STORE: mem_wr=1, same addressing as LOAD. SST is exactly one beat; VST is VLANES beats. Last ack -> pulse instr_done, -> FETCH.
- WB (1 cycle): sreg_we for VDOT/SLL/SLH; vreg_we for VADD/SMUL/VLD. wb_sel: VDOT=0, SLL/SLH=1, VADD/SMUL=2, VLD=3. Pulse instr_done, -> FETCH.
- mem_ack while neither mem_rd nor mem_wr is high is ignored. mem_rd and mem_wr are never high together.
- Minimum latency: NOP = 2 cycles with single-cycle ack. VLD = 3 + VLANES + 1 cycles.
- wb_sel, lane_idx and mem_addr are registered outputs. mem_rd and mem_wr are decoded from state.

Optional Feature:
SEQ_FPU_TIMEOUT_EN:
- Defined: a cycle counter runs in FPU. If fpu_done has not arrived after FPU_TIMEOUT cycles, the block pulses fpu_timeout (extra 1-bit output), skips WB (no register write), pulses instr_done and goes to FETCH.
- Undefined: FPU waits indefinitely; no fpu_timeout port and no counter.

Decomposition:
- seq_ctrl_pkg holds:
  - opcode localparams OP_VADD..OP_NOP;
  - the state encoding (RST, FETCH, DECODE, FPU, ADDR, LOAD, STORE, WB);
  - wb_sel codes WB_FPU_S, WB_SHIFT, WB_FPU_V, WB_LDBUF.
- One sub-module, seq_addr_gen: effective-address adder, lane counter and beat-address generation, with inputs ea_load, beat_adv and a last_beat output.

Test Plan:
- Reset, VLANES=4: memory returns NOP (0x9000) at addr 0, ack every cycle -> mem_addr 0 then 1; pc=2 after two instructions; instr_done pulses every 2 cycles.
- VLD: base_data=0x0010, instr=0x4A3E (offset -2) -> beats at 0x000E..0x0011; lane_we 4x, lane_idx 0..3; then vreg_we=1, wb_sel=3.
- VST with ack every third cycle: mem_wr held, address stable until each ack, 4 beats; base 0xFFFF, offset +1 -> addresses wrap to 0x0000..0x0003.
- J at pc=5, instr=0x8FFC -> next fetch at 6-4=2; fpu_done asserted in the fpu_start cycle is ignored, and a later assertion completes with sreg_we for VDOT.
- rst_n low mid-LOAD beat 2 -> mem_rd drops the same cycle, lane_idx=0; after release, fetch resumes at address 0.
- Opcode 0xF -> illegal and instr_done pulse together; with SEQ_FPU_TIMEOUT_EN and FPU_TIMEOUT=8, VADD without fpu_done -> fpu_timeout pulse, no vreg_we.
